// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: load/store bus sequencer that sits directly after the Mem stage.
//
// Behaviour:
//   - Each load or store from Mem runs as one request/response transaction on the
//     data-memory bus.
//   - The pipeline is stalled until the transaction completes.
//   - Load data is lane-extracted and sign/zero-extended, then returned to Mem.
//
// Optional feature (macro LSU_TIMEOUT_EN):
//   - A REQ+WAIT watchdog aborts the transaction after TIMEOUT_CYCLES cycles.
//   - On abort, BusErrOut pulses for one cycle.
//   - Without the macro the FSM waits indefinitely and BusErrOut is tied low.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   OpCodeIn          7'b0000011 load, 7'b0100011 store, anything else = no access
//   Funct3In          access size/sign (b,h,w,d,bu,hu,wu; unsupported = d)
//   RaddrIn, WaddrIn  load / store byte address
//   WdataIn           right-justified store data
//   LoadDataOut       extended load data, held until the next load response
//   StallOut          freeze upstream pipeline registers
//   BusReq*, BusWe, BusAddr, BusWdata, BusWstrb     request channel
//   BusRspValid, BusRdata                           response channel
//   BusErrOut         one-cycle pulse on timeout abort
//
// Handshake:
//   - BusReqValid is high for the whole REQ state.
//   - BusWe/BusAddr/BusWdata/BusWstrb come from registers latched in IDLE, so they
//     cannot change while BusReqValid is high.
//   - The request transfers on the first cycle with BusReqValid & BusReqReady.
//   - The response is a single BusRspValid pulse.
//   - It may coincide with the request handshake, or arrive in any later cycle.
//   - A BusRspValid seen outside REQ/WAIT is ignored.
module lsu_bus_ctrl #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  OpCodeIn,
  input  logic [2:0]  Funct3In,
  input  logic [63:0] RaddrIn,
  input  logic [63:0] WaddrIn,
  input  logic [63:0] WdataIn,
  output logic [63:0] LoadDataOut,
  output logic        StallOut,
  output logic        BusReqValid,
  input  logic        BusReqReady,
  output logic        BusWe,
  output logic [63:0] BusAddr,
  output logic [63:0] BusWdata,
  output logic [7:0]  BusWstrb,
  input  logic        BusRspValid,
  input  logic [63:0] BusRdata,
  output logic        BusErrOut
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // FSM state; observable hierarchically as dut.state
  state_t      state;

  logic        is_load;
  logic        is_store;
  logic        acc;
  logic [63:0] acc_addr;
  logic [7:0]  strb_next;

  logic [63:0] addr_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [7:0]  strb_q;
  logic [63:0] wdata_q;
  logic [63:0] load_data;
  logic [63:0] shifted;
  logic [63:0] ext_data;

  assign is_load  = (OpCodeIn == OP_LOAD);
  assign is_store = (OpCodeIn == OP_STORE);
  assign acc      = is_load | is_store;
  assign acc_addr = is_store ? WaddrIn : RaddrIn;

  // Strobes are shifted in 8 bits, so a misaligned access simply loses the lanes
  // that would fall past the doubleword boundary.
  always_comb begin
    strb_next = 8'h00;
    if (is_store) begin
      case (Funct3In)
        3'b000:  strb_next = 8'h01 << acc_addr[2:0];
        3'b001:  strb_next = 8'h03 << acc_addr[2:0];
        3'b010:  strb_next = 8'h0F << acc_addr[2:0];
        default: strb_next = 8'hFF;
      endcase
    end
  end

  always_comb begin
    shifted  = BusRdata >> {addr_q[2:0], 3'b000};
    ext_data = shifted;
    case (f3_q)
      3'b000:  ext_data = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  ext_data = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  ext_data = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  ext_data = {56'h0, shifted[7:0]};
      3'b101:  ext_data = {48'h0, shifted[15:0]};
      3'b110:  ext_data = {32'h0, shifted[31:0]};
      default: ext_data = shifted;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 9) ? $clog2(TIMEOUT_CYCLES + 1) : 9;
  logic [CW-1:0] cnt;
  logic          err_q;
  logic          timeout;
  // cnt equals the number of REQ+WAIT cycles already spent, so the abort fires
  // in the TIMEOUT_CYCLES-th such cycle.
  assign timeout   = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign BusErrOut = err_q;
`else
  assign BusErrOut = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= 64'h0;
      f3_q      <= 3'b000;
      we_q      <= 1'b0;
      strb_q    <= 8'h00;
      wdata_q   <= 64'h0;
      load_data <= 64'h0;
`ifdef LSU_TIMEOUT_EN
      cnt       <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
`ifdef LSU_TIMEOUT_EN
      err_q <= 1'b0;
      cnt   <= cnt + 1'b1;
`endif
      case (state)
        IDLE: begin
          if (acc) begin
            addr_q  <= acc_addr;
            f3_q    <= Funct3In;
            we_q    <= is_store;
            strb_q  <= strb_next;
            wdata_q <= is_store ? (WdataIn << {acc_addr[2:0], 3'b000}) : 64'h0;
            state   <= REQ;
`ifdef LSU_TIMEOUT_EN
            cnt     <= '0;
`endif
          end
        end
        REQ: begin
          if (BusReqReady) begin
            if (BusRspValid) begin
              if (!we_q) load_data <= ext_data;
              state <= DONE;
            end else begin
              state <= WAIT;
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (timeout) begin
            err_q     <= 1'b1;
            load_data <= 64'h0;
            state     <= DONE;
          end
`endif
        end
        WAIT: begin
          if (BusRspValid) begin
            if (!we_q) load_data <= ext_data;
            state <= DONE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (timeout) begin
            err_q     <= 1'b1;
            load_data <= 64'h0;
            state     <= DONE;
          end
`endif
        end
        default: state <= IDLE;  // DONE: one unstalled cycle
      endcase
    end
  end

  // In IDLE the stall must assert in the same cycle the access appears.
  assign StallOut    = (state == IDLE) ? acc : ((state == REQ) || (state == WAIT));
  assign BusReqValid = (state == REQ);
  assign BusWe       = we_q;
  assign BusAddr     = {addr_q[63:3], 3'b000};
  assign BusWdata    = wdata_q;
  assign BusWstrb    = strb_q;
  assign LoadDataOut = load_data;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: directed loads/stores, handshake
// back-pressure, reset in WAIT, a short random load sequence and, when built
// with LSU_TIMEOUT_EN, the watchdog abort (TIMEOUT_CYCLES = 8).
module tb_lsu_bus_ctrl;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_NOP   = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  OpCodeIn;
  logic [2:0]  Funct3In;
  logic [63:0] RaddrIn;
  logic [63:0] WaddrIn;
  logic [63:0] WdataIn;
  logic [63:0] LoadDataOut;
  logic        StallOut;
  logic        BusReqValid;
  logic        BusReqReady;
  logic        BusWe;
  logic [63:0] BusAddr;
  logic [63:0] BusWdata;
  logic [7:0]  BusWstrb;
  logic        BusRspValid;
  logic [63:0] BusRdata;
  logic        BusErrOut;

  // clock / reset
  always #5 clk = ~clk;

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .OpCodeIn(OpCodeIn), .Funct3In(Funct3In),
    .RaddrIn(RaddrIn), .WaddrIn(WaddrIn), .WdataIn(WdataIn),
    .LoadDataOut(LoadDataOut), .StallOut(StallOut),
    .BusReqValid(BusReqValid), .BusReqReady(BusReqReady),
    .BusWe(BusWe), .BusAddr(BusAddr), .BusWdata(BusWdata), .BusWstrb(BusWstrb),
    .BusRspValid(BusRspValid), .BusRdata(BusRdata), .BusErrOut(BusErrOut)
  );

  int          passed = 0;
  int          total  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_load = 64'h0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [63:0] load_model(input logic [2:0] f3, input logic [2:0] a,
                                             input logic [63:0] rd);
    logic [63:0] s;
    s = rd >> (8 * a);
    case (f3)
      3'b000:  return {{56{s[7]}}, s[7:0]};
      3'b001:  return {{48{s[15]}}, s[15:0]};
      3'b010:  return {{32{s[31]}}, s[31:0]};
      3'b100:  return {56'h0, s[7:0]};
      3'b101:  return {48'h0, s[15:0]};
      3'b110:  return {32'h0, s[31:0]};
      default: return s;
    endcase
  endfunction

  function automatic logic [7:0] strb_model(input logic [2:0] f3, input logic [2:0] a);
    logic [15:0] w;
    case (f3)
      3'b000:  w = 16'h0001 << a;
      3'b001:  w = 16'h0003 << a;
      3'b010:  w = 16'h000F << a;
      default: w = 16'h00FF;
    endcase
    return w[7:0];
  endfunction

  // Driver + bus responder for one access. ready_dly = REQ cycles before ready,
  // rsp_dly = 0 for a response in the handshake cycle, n for the n-th WAIT cycle.
  task automatic do_access(input string tag, input logic is_load, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                           input int ready_dly, input int rsp_dly);
    int          stalls = 0;
    int          hs = 0;
    int          req_cyc = 0;
    int          wait_cyc = 0;
    bit          accepted = 0;
    bit          done = 0;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_strb;
    logic [63:0] exp_ld;
    exp_wdata = is_load ? 64'h0 : (wd << (8 * a[2:0]));
    exp_strb  = is_load ? 8'h00 : strb_model(f3, a[2:0]);
    @(negedge clk);
    OpCodeIn = is_load ? OP_LOAD : OP_STORE;
    Funct3In = f3;
    RaddrIn  = is_load ? a : ~a;
    WaddrIn  = is_load ? ~a : a;
    WdataIn  = wd;
    BusRdata = rd;
    if (is_load) exp_q.push_back(load_model(f3, a[2:0], rd));
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      BusReqReady = 1'b0;
      BusRspValid = 1'b0;
      if (BusReqValid) begin
        if (req_cyc == ready_dly) begin
          BusReqReady = 1'b1;
          BusRspValid = (rsp_dly == 0);
        end
        req_cyc++;
      end else if (accepted) begin
        BusRspValid = (wait_cyc == rsp_dly - 1);
        wait_cyc++;
      end
      #1;
      if (BusReqValid) begin
        check({tag, "_addr"},  BusAddr,  {a[63:3], 3'b000});
        check({tag, "_we"},    BusWe,    !is_load);
        check({tag, "_strb"},  BusWstrb, exp_strb);
        if (!is_load) check({tag, "_wdata"}, BusWdata, exp_wdata);
        if (BusReqReady) begin
          hs++;
          accepted = 1;
        end
      end
      if (StallOut) stalls++;
      else if (cyc > 0) done = 1;
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_stalls"}, stalls, 2 + ready_dly + rsp_dly);
    check({tag, "_handshakes"}, hs, 1);
    check({tag, "_err"}, BusErrOut, 1'b0);
    if (is_load) begin
      exp_ld = exp_q.pop_front();
      check({tag, "_ldata"}, LoadDataOut, exp_ld);
      last_load = exp_ld;
    end else begin
      check({tag, "_ldata_held"}, LoadDataOut, last_load);
    end
    OpCodeIn    = OP_NOP;
    BusReqReady = 1'b0;
    BusRspValid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    OpCodeIn = OP_NOP; Funct3In = 3'b000;
    RaddrIn = 64'h0; WaddrIn = 64'h0; WdataIn = 64'h0;
    BusReqReady = 1'b0; BusRspValid = 1'b0; BusRdata = 64'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", StallOut, 1'b0);
    check("rst_valid", BusReqValid, 1'b0);
    check("rst_ldata", LoadDataOut, 64'h0);
    check("rst_we", BusWe, 1'b0);
    check("rst_strb", BusWstrb, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Loads: minimum latency, one WAIT cycle, byte sign/zero extension
    do_access("ld_fast", 1'b1, 3'b011, 64'h80000008, 64'h0, 64'h1122334455667788, 0, 0);
    do_access("ld_wait", 1'b1, 3'b011, 64'h80000008, 64'h0, 64'hCAFEF00D12345678, 0, 1);
    do_access("lb",  1'b1, 3'b000, 64'h80000003, 64'h0, 64'h0000000080000000, 0, 1);
    do_access("lbu", 1'b1, 3'b100, 64'h80000003, 64'h0, 64'h0000000080000000, 0, 1);
    do_access("lh",  1'b1, 3'b001, 64'h80000006, 64'h0, 64'h8001000000000000, 1, 2);
    do_access("lhu", 1'b1, 3'b101, 64'h80000006, 64'h0, 64'h8001000000000000, 0, 0);
    do_access("lw",  1'b1, 3'b010, 64'h80000004, 64'h0, 64'h89ABCDEF00000000, 0, 1);
    do_access("lwu", 1'b1, 3'b110, 64'h80000004, 64'h0, 64'h89ABCDEF00000000, 2, 0);
    do_access("l111", 1'b1, 3'b111, 64'h80000005, 64'h0, 64'hFEDCBA9876543210, 0, 1);

    // Stores: lane placement, back-pressure, misaligned truncation
    do_access("sh",  1'b0, 3'b001, 64'h80000006, 64'hABCD, 64'h0, 0, 1);
    do_access("sb",  1'b0, 3'b000, 64'h80000001, 64'h5A, 64'h0, 0, 0);
    do_access("sw_bp", 1'b0, 3'b010, 64'h80000004, 64'h12345678, 64'h0, 5, 1);
    do_access("sw_mis", 1'b0, 3'b010, 64'h80000006, 64'hDEADBEEF, 64'h0, 0, 1);
    do_access("sd",  1'b0, 3'b011, 64'h80000010, 64'h0123456789ABCDEF, 64'h0, 1, 0);

    // Random loads
    for (int i = 0; i < 6; i++) begin
      logic [2:0]  f3;
      logic [63:0] a;
      logic [63:0] rd;
      f3 = 3'($urandom_range(0, 7));
      a  = {32'h0, 32'h80000000 | 32'($urandom_range(0, 255))};
      rd = {$urandom(), $urandom()};
      do_access("ld_rand", 1'b1, f3, a, 64'h0, rd,
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset while in WAIT drops the transaction immediately
    @(negedge clk);
    OpCodeIn = OP_LOAD; Funct3In = 3'b011; RaddrIn = 64'h80000018; WaddrIn = 64'h0;
    @(negedge clk);
    BusReqReady = 1'b1;
    @(negedge clk);
    BusReqReady = 1'b0;
    #1;
    check("wait_stall", StallOut, 1'b1);
    check("wait_valid", BusReqValid, 1'b0);
    rst = 1'b1;
    OpCodeIn = OP_NOP;
    #1;
    check("arst_stall", StallOut, 1'b0);
    check("arst_valid", BusReqValid, 1'b0);
    check("arst_ldata", LoadDataOut, 64'h0);
    @(posedge clk);
    #1;
    check("arst_edge_stall", StallOut, 1'b0);
    check("arst_edge_valid", BusReqValid, 1'b0);
    check("arst_edge_ldata", LoadDataOut, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    last_load = 64'h0;
    do_access("post_rst_store", 1'b0, 3'b000, 64'h80000007, 64'h77, 64'h0, 0, 0);
    do_access("post_rst_lb", 1'b1, 3'b000, 64'h80000007, 64'h0, 64'h7F00000000000000, 0, 1);

`ifdef LSU_TIMEOUT_EN
    // Watchdog: no ready ever; IDLE cycle, 8 REQ cycles, then DONE with the error pulse
    begin
      int err_cyc;
      err_cyc = -1;
      @(negedge clk);
      OpCodeIn = OP_LOAD; Funct3In = 3'b011; RaddrIn = 64'h80000020;
      BusReqReady = 1'b0; BusRspValid = 1'b0;
      for (int c = 0; c < 40 && err_cyc < 0; c++) begin
        if (c > 0) @(negedge clk);
        #1;
        if (BusErrOut) err_cyc = c;
      end
      check("to_cycle", err_cyc, 9);
      check("to_ldata", LoadDataOut, 64'h0);
      check("to_done_stall", StallOut, 1'b0);
      OpCodeIn = OP_NOP;
      @(negedge clk);
      #1;
      check("to_err_pulse", BusErrOut, 1'b0);
      check("to_idle_stall", StallOut, 1'b0);
    end
`endif

    repeat (2) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
